// File: rtl/mii_pkg.sv
// Shared MII definitions for the frame generator and frame checker.
// Holds the receive FSM state type, default control/pattern codes and
// the bit positions of the per-frame error flags.
package mii_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } mii_rx_state_t;

  localparam logic [7:0] DEF_IDLE_CODE      = 8'h07;
  localparam logic [7:0] DEF_START_CODE     = 8'hFB;
  localparam logic [7:0] DEF_TERMINATE_CODE = 8'hFD;
  localparam logic [7:0] DEF_DATA_PATTERN   = 8'hAA;

  localparam int unsigned ERR_SHORT   = 0;
  localparam int unsigned ERR_LONG    = 1;
  localparam int unsigned ERR_PATTERN = 2;
  localparam int unsigned ERR_ABORT   = 3;
  localparam int unsigned ERR_W       = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc (increment enable),
//        count (current value).
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mii_frame_checker.sv
// MII receive-side frame checker: delimits frames on START/TERMINATE,
// forwards payload bytes, checks length and content, and reports a
// one-cycle per-frame status plus saturating good/bad frame counters.
// Ports: clk, i_rst_n (async active-low), i_rx_data/i_rx_ctrl (MII
//        character in), o_data/o_data_valid/o_sof (payload out),
//        o_frame_done/o_frame_ok/o_frame_len/o_err_flags (frame status),
//        o_err_seq (stray character), o_good_cnt/o_bad_cnt (counters).
module mii_frame_checker
  import mii_pkg::*;
#(
  parameter int unsigned DATA_LENGTH       = 46,
  parameter int unsigned MAX_LENGTH        = 1500,
  parameter logic [7:0]  IDLE_CODE         = DEF_IDLE_CODE,
  parameter logic [7:0]  START_CODE        = DEF_START_CODE,
  parameter logic [7:0]  TERMINATE_CODE    = DEF_TERMINATE_CODE,
  parameter logic [7:0]  DATA_CHAR_PATTERN = DEF_DATA_PATTERN,
  parameter bit          CHECK_PATTERN     = 1'b1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_ctrl,
  output logic [7:0]        o_data,
  output logic              o_data_valid,
  output logic              o_sof,
  output logic              o_frame_done,
  output logic              o_frame_ok,
  output logic [15:0]       o_frame_len,
  output logic [ERR_W-1:0]  o_err_flags,
  output logic              o_err_seq,
  output logic [15:0]       o_good_cnt,
  output logic [15:0]       o_bad_cnt
);

  localparam int unsigned     LEN_W   = 16;
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LENGTH + 1);

  mii_rx_state_t    state;
  logic [LEN_W-1:0] len;
  logic             pat_err;
  logic [ERR_W-1:0] close_flags_c;

  // Status of the frame being closed by the current control character.
  always_comb begin
    close_flags_c              = '0;
    close_flags_c[ERR_SHORT]   = (len < LEN_W'(DATA_LENGTH));
    close_flags_c[ERR_LONG]    = (len > LEN_W'(MAX_LENGTH));
    close_flags_c[ERR_PATTERN] = pat_err;
    close_flags_c[ERR_ABORT]   = (i_rx_data != TERMINATE_CODE);
  end

  // Receive FSM with registered per-cycle outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      len          <= '0;
      pat_err      <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_frame_len  <= '0;
      o_err_flags  <= '0;
      o_err_seq    <= 1'b0;
    end else begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_frame_len  <= '0;
      o_err_flags  <= '0;
      o_err_seq    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_ctrl && (i_rx_data == START_CODE)) begin
            len     <= '0;
            pat_err <= 1'b0;
            state   <= ST_DATA;
          end else if (!(i_rx_ctrl && (i_rx_data == IDLE_CODE))) begin
            o_err_seq <= 1'b1;
          end
        end
        ST_DATA: begin
          if (!i_rx_ctrl) begin
            o_data       <= i_rx_data;
            o_data_valid <= 1'b1;
            // len only returns to 0 on a new START, so 0 marks the first byte.
            o_sof        <= (len == '0);
            if (len != LEN_SAT) begin
              len <= len + LEN_W'(1);
            end
            if (CHECK_PATTERN && (i_rx_data != DATA_CHAR_PATTERN)) begin
              pat_err <= 1'b1;
            end
          end else begin
            o_frame_done <= 1'b1;
            o_frame_len  <= len;
            o_err_flags  <= close_flags_c;
            o_frame_ok   <= (close_flags_c == '0);
            if (i_rx_data == START_CODE) begin
              // Abort-and-restart: the new frame opens in the same cycle.
              len     <= '0;
              pat_err <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_good_cnt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .inc   (o_frame_done & o_frame_ok),
    .count (o_good_cnt)
  );

  sat_counter #(.WIDTH(16)) u_bad_cnt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .inc   (o_frame_done & ~o_frame_ok),
    .count (o_bad_cnt)
  );

endmodule

// File: tb/tb_mii_frame_checker.sv
// Self-checking bench for mii_frame_checker: directed frames from the test
// plan plus randomized frame traffic, compared each cycle against a
// frame-level reference model built from byte queues.
module tb_mii_frame_checker;

  localparam logic [7:0] C_IDLE = 8'h07;
  localparam logic [7:0] C_STRT = 8'hFB;
  localparam logic [7:0] C_TERM = 8'hFD;
  localparam logic [7:0] C_PAT  = 8'hAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_ctrl;
  logic [7:0]  data;
  logic        data_valid, sof, frame_done, frame_ok, err_seq;
  logic [15:0] frame_len, good_cnt, bad_cnt;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  mii_frame_checker dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_ctrl    (rx_ctrl),
    .o_data       (data),
    .o_data_valid (data_valid),
    .o_sof        (sof),
    .o_frame_done (frame_done),
    .o_frame_ok   (frame_ok),
    .o_frame_len  (frame_len),
    .o_err_flags  (err_flags),
    .o_err_seq    (err_seq),
    .o_good_cnt   (good_cnt),
    .o_bad_cnt    (bad_cnt)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  bit          in_frame;
  logic [7:0]  frame_q[$];
  logic [7:0]  e_data;
  logic        e_valid, e_sof, e_done, e_ok, e_seq;
  logic [15:0] e_len, e_good, e_bad;
  logic [3:0]  e_flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    in_frame = 1'b0;
    frame_q.delete();
    e_data = '0; e_valid = 0; e_sof = 0; e_done = 0; e_ok = 0; e_seq = 0;
    e_len = '0; e_flags = '0; e_good = '0; e_bad = '0;
  endfunction

  function automatic void close_frame(input bit aborted);
    int n;
    bit pat;
    n   = frame_q.size();
    pat = 1'b0;
    foreach (frame_q[i]) if (frame_q[i] != C_PAT) pat = 1'b1;
    e_done  = 1'b1;
    e_len   = 16'((n > 1501) ? 1501 : n);
    e_flags = {aborted, pat, (n > 1500), (n < 46)};
    e_ok    = (e_flags == 4'b0000);
  endfunction

  // Expected outputs one cycle after character (d, c) is sampled.
  function automatic void model_step(input logic [7:0] d, input logic c);
    if (e_done) begin
      if (e_ok) begin
        if (e_good != 16'hFFFF) e_good = e_good + 16'd1;
      end else begin
        if (e_bad != 16'hFFFF) e_bad = e_bad + 16'd1;
      end
    end
    e_data = '0; e_valid = 0; e_sof = 0; e_done = 0; e_ok = 0; e_seq = 0;
    e_len = '0; e_flags = '0;
    if (!in_frame) begin
      if (c && d == C_STRT) begin
        in_frame = 1'b1;
        frame_q.delete();
      end else if (!(c && d == C_IDLE)) begin
        e_seq = 1'b1;
      end
    end else if (!c) begin
      e_valid = 1'b1;
      e_data  = d;
      e_sof   = (frame_q.size() == 0);
      frame_q.push_back(d);
    end else begin
      close_frame(d != C_TERM);
      if (d == C_STRT) frame_q.delete();
      else in_frame = 1'b0;
    end
  endfunction

  task automatic compare_all();
    chk("data",       32'(data),       32'(e_data));
    chk("data_valid", 32'(data_valid), 32'(e_valid));
    chk("sof",        32'(sof),        32'(e_sof));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_ok",   32'(frame_ok),   32'(e_ok));
    chk("frame_len",  32'(frame_len),  32'(e_len));
    chk("err_flags",  32'(err_flags),  32'(e_flags));
    chk("err_seq",    32'(err_seq),    32'(e_seq));
    chk("good_cnt",   32'(good_cnt),   32'(e_good));
    chk("bad_cnt",    32'(bad_cnt),    32'(e_bad));
  endtask

  task automatic step(input logic [7:0] d, input logic c);
    @(negedge clk);
    rx_data = d;
    rx_ctrl = c;
    model_step(d, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Payload of n bytes, byte at bad_idx replaced by 8'h55 (-1 = none).
  task automatic send_body(input int n, input int bad_idx);
    for (int i = 0; i < n; i++) step((i == bad_idx) ? 8'h55 : C_PAT, 1'b0);
  endtask

  task automatic send_frame(input int n, input int bad_idx, input logic [7:0] term);
    step(C_STRT, 1'b1);
    send_body(n, bad_idx);
    step(term, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_data = C_IDLE;
    rx_ctrl = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, bad, gap, sel;
    logic [7:0] term;
    bit open;

    rst_n   = 1'b0;
    rx_data = C_IDLE;
    rx_ctrl = 1'b1;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame
    for (int i = 0; i < 12; i++) step(C_IDLE, 1'b1);
    send_frame(46, -1, C_TERM);
    chk("nominal_len", 32'(frame_len), 32'd46);
    chk("nominal_ok", 32'(frame_ok), 32'd1);
    step(C_IDLE, 1'b1);
    chk("nominal_good", 32'(good_cnt), 32'd1);

    // Short and long frames
    do_reset();
    send_frame(10, -1, C_TERM);
    chk("short_flags", 32'(err_flags), 32'h1);
    send_frame(1501, -1, C_TERM);
    chk("long_len", 32'(frame_len), 32'd1501);
    chk("long_flags", 32'(err_flags), 32'h2);
    step(C_IDLE, 1'b1);
    chk("short_long_bad", 32'(bad_cnt), 32'd2);

    // Pattern error
    send_frame(46, 45, C_TERM);
    chk("pattern_flags", 32'(err_flags), 32'h4);

    // Abort and restart
    do_reset();
    step(C_STRT, 1'b1);
    send_body(20, -1);
    step(C_STRT, 1'b1);
    chk("abort_len", 32'(frame_len), 32'd20);
    chk("abort_flags", 32'(err_flags), 32'h9);
    send_body(46, -1);
    step(C_TERM, 1'b1);
    chk("restart_ok", 32'(frame_ok), 32'd1);
    step(C_IDLE, 1'b1);
    chk("restart_good", 32'(good_cnt), 32'd1);
    chk("restart_bad", 32'(bad_cnt), 32'd1);

    // Stray character and idle abort; zero-length frame
    step(C_PAT, 1'b0);
    chk("stray_seq", 32'(err_seq), 32'd1);
    send_frame(50, -1, C_IDLE);
    chk("idle_abort_flags", 32'(err_flags), 32'h8);
    send_frame(0, -1, C_TERM);
    chk("zero_len_flags", 32'(err_flags), 32'h1);

    // Reset mid-frame
    step(C_STRT, 1'b1);
    send_body(30, -1);
    do_reset();
    send_frame(46, -1, C_TERM);
    step(C_IDLE, 1'b1);
    chk("post_reset_good", 32'(good_cnt), 32'd1);
    chk("post_reset_bad", 32'(bad_cnt), 32'd0);

    // Randomized traffic
    open = 1'b0;
    for (int f = 0; f < 80; f++) begin
      if (!open) begin
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          sel = int'($urandom_range(0, 9));
          if (sel == 0)      step(8'($urandom), 1'b0);
          else if (sel == 1) step(C_TERM, 1'b1);
          else               step(C_IDLE, 1'b1);
        end
        step(C_STRT, 1'b1);
      end
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      n = int'($urandom_range(1495, 1505));
      else if (sel < 4)  n = int'($urandom_range(0, 2)) + 44 * int'($urandom_range(0, 1));
      else               n = int'($urandom_range(0, 120));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : -1;
      send_body(n, bad);
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       term = C_TERM;
      else if (sel == 7) term = C_STRT;
      else if (sel == 8) term = C_IDLE;
      else               term = 8'hE0;
      step(term, 1'b1);
      open = (term == C_STRT);
    end
    step(C_IDLE, 1'b1);
    step(C_IDLE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
